ball_engine: RTL and testbench
==============================

# ball_engine

Pong ball for the pixel-animation datapath. It owns the ball position and direction and advances once per animation strobe. It bounces off the top/bottom display edges and off the two paddles, whose edge coordinates come from the paddle instances. It also flags points and runs a serve delay, then feeds its edges to the renderer and the score logic.

## Interface
- `SIZE`, 8: half ball width/height, px
- `IX`, 320 / `IY`, 240: serve position of ball centre
- `SPEED_X`, 2 / `SPEED_Y`, 2: px moved per strobe on each axis
- `D_WIDTH`, 639 / `D_HEIGHT`, 470: display extent
- `SERVE_FRAMES`, 60: strobes held at serve position; legal range 1..255

- `in_clock` in 1: base clock
- `in_reset` in 1: asynchronous, active-high reset
- `in_ani_stb` in 1: animation strobe, one `in_clock` cycle per frame
- `in_animate` in 1: when low, all motion and the serve count freeze
- `in_lbar_x2`, `in_lbar_y1`, `in_lbar_y2` in 12 each: left paddle right edge, top, bottom
- `in_rbar_x1`, `in_rbar_y1`, `in_rbar_y2` in 12 each: right paddle left edge, top, bottom
- `out_x1`, `out_x2`, `out_y1`, `out_y2` out 12 each: ball edges = centre ∓ `SIZE`
- `out_point_l` out 1: left player scored (ball exited right); 1-cycle pulse
- `out_point_r` out 1: right player scored (ball exited left); 1-cycle pulse
- `out_state` out 2: SERVE=0, PLAY=1, SCORED=2

## Operation
- Internal registers:
  - centre `x`, `y` (12 b)
  - `dx`, `dy` (1 b each; 1 = right/down)
  - serve counter (8 b)
  - state
- Strobe event `stb` = `in_ani_stb & in_animate`.
- SERVE:
  - Centre is held at `IX`,`IY`.
  - Each `stb` increments the counter.
  - At the `stb` where the counter equals `SERVE_FRAMES-1`: clear the counter and go to PLAY. Position is unchanged on that strobe.
- PLAY, on each `stb`, vertical axis:
  - Bottom bounce when `dy` is down and `y+SIZE+SPEED_Y >= D_HEIGHT`: `y <= D_HEIGHT-1-SIZE`, `dy` up.
  - Top bounce when `dy` is up and `y <= SIZE+SPEED_Y`: `y <= SIZE`, `dy` down.
  - Otherwise `y` moves by `SPEED_Y`.
- PLAY, on each `stb`, horizontal axis, priority paddle hit > miss > move:
  - Vertical overlap with a paddle: ball `y2 >= bar_y1` and ball `y1 <= bar_y2`.
  - Left hit: `dx` left, `x-SIZE >= in_lbar_x2`, `x-SIZE-SPEED_X <= in_lbar_x2`, overlap → `x <= in_lbar_x2+SIZE+1`, `dx` right.
  - Right hit: `dx` right, `x+SIZE <= in_rbar_x1`, `x+SIZE+SPEED_X >= in_rbar_x1`, overlap → `x <= in_rbar_x1-SIZE-1`, `dx` left.
  - Left miss: `dx` left and `x <= SIZE+SPEED_X` → SCORED with `out_point_r`.
  - Right miss: `dx` right and `x+SIZE+SPEED_X >= D_WIDTH` → SCORED with `out_point_l`.
  - On a miss, `x`/`y` keep their current values for that strobe.
- Vertical and horizontal events are evaluated independently in the same strobe. A corner hit both bounces and reflects.
- SCORED:
  - Lasts exactly one `in_clock` cycle and is not strobe-gated.
  - Then go to SERVE with centre at `IX`,`IY`, `dy` down, counter 0.
  - `dx` points toward the player who conceded.
- Arithmetic: all comparisons use 13-bit unsigned intermediates, so no 12-bit wrap occurs. Paddle inputs are not range-checked. A paddle driven to 4095 never overlaps.
- Reset, at any time including mid-PLAY or SCORED:
  - state SERVE, `x=IX`, `y=IY`, `dx` right, `dy` down, counter 0
  - pulses 0, outputs `IX∓SIZE`, `IY∓SIZE`

## Timing
- All outputs are registered. A `stb` sampled at edge *n* changes the outputs after edge *n*; latency is 1 clock.
- Paddle inputs are sampled only on `stb` edges and may change freely between strobes.
- `out_point_*` is high for exactly one clock, coincident with `out_state==SCORED`. The two pulses are never high together.
- A `stb` arriving while in SCORED is ignored; the serve count starts on the first `stb` after SERVE is entered.
- `in_animate` low: state, position and counter hold. A SCORED→SERVE transition still completes.

## Structure
- Shared package `pong_pkg` holds:
  - state enum (SERVE/PLAY/SCORED)
  - `COORD_W=12`
  - `D_WIDTH`, `D_HEIGHT` defaults, also used by the paddle and renderer blocks
- One natural sub-module: `serve_timer`, the strobe-counting delay with `start`/`done`. Motion and collision stay in `ball_engine`.

## Test plan
- Reset, then 59 `stb`: outputs 312/328/232/248, state SERVE. 60th `stb` → PLAY. Next `stb` → `x1=314`, `y1=234`.
- Right paddle `x1=619`, `y1=0`, `y2=470`: `x` reaches 610. Next `stb`: `x` stays 610 and `dx` flips. Following `stb`: `x=608`.
- Right paddle `y1=y2=4095`: at `x=630` a `stb` gives SCORED with `out_point_l` high 1 cycle. Next cycle: SERVE at 320/240, `dx` right.
- Bottom bounce with `y=460`, `dy` down: `stb` → `y=461`, `dy` up. Next `stb` → `y=459`.
- `in_animate=0` with 10 strobes mid-PLAY: no output change. Assert `in_reset` asynchronously between clock edges: outputs return to 312/328/232/248 immediately, no pulse.
- Left miss and top bounce on the same `stb`: `out_point_r` pulses, vertical state updates, no left-paddle hit reported.

Source files
------------

// File: rtl/pong_pkg.sv
// Types and display constants shared by the pong ball, paddle and renderer blocks.
package pong_pkg;
  localparam int COORD_W  = 12;
  localparam int D_WIDTH  = 639;
  localparam int D_HEIGHT = 470;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;
endpackage

// File: rtl/ball_engine_if.sv
// Ball engine bus: strobe/animate controls and paddle edges in, ball edges and score pulses out.
interface ball_engine_if;
  import pong_pkg::*;

  logic               in_ani_stb;
  logic               in_animate;
  logic [COORD_W-1:0] in_lbar_x2;
  logic [COORD_W-1:0] in_lbar_y1;
  logic [COORD_W-1:0] in_lbar_y2;
  logic [COORD_W-1:0] in_rbar_x1;
  logic [COORD_W-1:0] in_rbar_y1;
  logic [COORD_W-1:0] in_rbar_y2;
  logic [COORD_W-1:0] out_x1;
  logic [COORD_W-1:0] out_x2;
  logic [COORD_W-1:0] out_y1;
  logic [COORD_W-1:0] out_y2;
  logic               out_point_l;
  logic               out_point_r;
  state_t             out_state;

  modport master (
    output in_ani_stb, in_animate, in_lbar_x2, in_lbar_y1, in_lbar_y2,
           in_rbar_x1, in_rbar_y1, in_rbar_y2,
    input  out_x1, out_x2, out_y1, out_y2, out_point_l, out_point_r, out_state
  );

  modport slave (
    input  in_ani_stb, in_animate, in_lbar_x2, in_lbar_y1, in_lbar_y2,
           in_rbar_x1, in_rbar_y1, in_rbar_y2,
    output out_x1, out_x2, out_y1, out_y2, out_point_l, out_point_r, out_state
  );
endinterface

// File: rtl/serve_timer.sv
// Serve delay: counts strobes while start is held; done fires combinationally on the last one.
// Counter clears whenever start is low, so each serve begins from zero.
module serve_timer #(
  parameter int unsigned FRAMES = 60
) (
  input  logic in_clock,
  input  logic in_reset,
  input  logic stb,
  input  logic start,
  output logic done
);
  localparam logic [7:0] LAST = 8'(FRAMES - 1);

  logic [7:0] count;

  assign done = start & stb & (count == LAST);

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset)      count <= 8'd0;
    else if (!start)   count <= 8'd0;
    else if (done)     count <= 8'd0;
    else if (stb)      count <= count + 8'd1;
  end
endmodule

// File: rtl/ball_engine.sv
// Pong ball: position/direction state advanced once per animation strobe, with wall/paddle bounces.
// Outputs come straight from state registers (1-clock latency); no backpressure, strobe-paced.
module ball_engine
  import pong_pkg::*;
#(
  parameter int SIZE         = 8,
  parameter int IX           = 320,
  parameter int IY           = 240,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 2,
  parameter int D_WIDTH      = pong_pkg::D_WIDTH,
  parameter int D_HEIGHT     = pong_pkg::D_HEIGHT,
  parameter int SERVE_FRAMES = 60
) (
  input  logic         in_clock,
  input  logic         in_reset,
  ball_engine_if.slave bus
);
  // One extra bit keeps every sum and compare free of 12-bit wrap.
  typedef logic [COORD_W:0] wide_t;

  localparam wide_t SZ  = wide_t'(SIZE);
  localparam wide_t SPX = wide_t'(SPEED_X);
  localparam wide_t SPY = wide_t'(SPEED_Y);
  localparam wide_t DW  = wide_t'(D_WIDTH);
  localparam wide_t DH  = wide_t'(D_HEIGHT);

  state_t             state, state_nxt;
  logic [COORD_W-1:0] x, y, x_nxt, y_nxt, y_move;
  logic               dx, dy, dx_nxt, dy_nxt;
  logic               point_l, point_r, pl_nxt, pr_nxt;
  logic               stb, serve_done;
  logic               ov_l, ov_r, hit_l, hit_r, miss_l, miss_r, bnc_bot, bnc_top;
  wide_t              xw, yw, by1, by2, lx2, rx1;

  assign stb = bus.in_ani_stb & bus.in_animate;
  assign xw  = {1'b0, x};
  assign yw  = {1'b0, y};
  assign by1 = yw - SZ;
  assign by2 = yw + SZ;
  assign lx2 = {1'b0, bus.in_lbar_x2};
  assign rx1 = {1'b0, bus.in_rbar_x1};

  assign ov_l    = (by2 >= {1'b0, bus.in_lbar_y1}) && (by1 <= {1'b0, bus.in_lbar_y2});
  assign ov_r    = (by2 >= {1'b0, bus.in_rbar_y1}) && (by1 <= {1'b0, bus.in_rbar_y2});
  assign hit_l   = !dx && (xw >= lx2 + SZ) && (xw <= lx2 + SZ + SPX) && ov_l;
  assign hit_r   = dx && (xw + SZ <= rx1) && (xw + SZ + SPX >= rx1) && ov_r;
  assign miss_l  = !dx && (xw <= SZ + SPX);
  assign miss_r  = dx && (xw + SZ + SPX >= DW);
  assign bnc_bot = dy && (yw + SZ + SPY >= DH);
  assign bnc_top = !dy && (yw <= SZ + SPY);

  assign y_move = bnc_bot ? COORD_W'(DH - wide_t'(1) - SZ) :
                  bnc_top ? COORD_W'(SZ) :
                  dy      ? COORD_W'(yw + SPY) : COORD_W'(yw - SPY);

  serve_timer #(.FRAMES(SERVE_FRAMES)) u_serve_timer (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .stb      (stb),
    .start    (state == SERVE),
    .done     (serve_done)
  );

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    dx_nxt    = dx;
    dy_nxt    = dy;
    pl_nxt    = 1'b0;
    pr_nxt    = 1'b0;
    case (state)
      SERVE: if (serve_done) state_nxt = PLAY;
      PLAY: if (stb) begin
        dy_nxt = (bnc_bot | bnc_top) ? ~dy : dy;
        if (hit_l) begin
          x_nxt  = COORD_W'(lx2 + SZ + wide_t'(1));
          dx_nxt = 1'b1;
          y_nxt  = y_move;
        end else if (hit_r) begin
          x_nxt  = COORD_W'(rx1 - SZ - wide_t'(1));
          dx_nxt = 1'b0;
          y_nxt  = y_move;
        end else if (miss_l) begin
          state_nxt = SCORED;
          pr_nxt    = 1'b1;
        end else if (miss_r) begin
          state_nxt = SCORED;
          pl_nxt    = 1'b1;
        end else begin
          x_nxt = dx ? COORD_W'(xw + SPX) : COORD_W'(xw - SPX);
          y_nxt = y_move;
        end
      end
      SCORED: begin
        // Serve toward whoever conceded: a left-player point means the right side missed.
        state_nxt = SERVE;
        x_nxt     = COORD_W'(IX);
        y_nxt     = COORD_W'(IY);
        dy_nxt    = 1'b1;
        dx_nxt    = point_l;
      end
      default: state_nxt = SERVE;
    endcase
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state   <= SERVE;
      x       <= COORD_W'(IX);
      y       <= COORD_W'(IY);
      dx      <= 1'b1;
      dy      <= 1'b1;
      point_l <= 1'b0;
      point_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      dx      <= dx_nxt;
      dy      <= dy_nxt;
      point_l <= pl_nxt;
      point_r <= pr_nxt;
    end
  end

  assign bus.out_x1      = COORD_W'(xw - SZ);
  assign bus.out_x2      = COORD_W'(xw + SZ);
  assign bus.out_y1      = COORD_W'(yw - SZ);
  assign bus.out_y2      = COORD_W'(yw + SZ);
  assign bus.out_point_l = point_l;
  assign bus.out_point_r = point_r;
  assign bus.out_state   = state;
endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: directed scenarios plus a randomized run against a frame-level ball model.
module tb_ball_engine;
  import pong_pkg::*;

  localparam int SIZE = 8, IX = 320, IY = 240, SX = 2, SY = 2;
  localparam int DW = 639, DH = 470, SF = 60;

  logic in_clock = 1'b0;
  logic in_reset = 1'b0;
  ball_engine_if bus();

  ball_engine #(
    .SIZE(SIZE), .IX(IX), .IY(IY), .SPEED_X(SX), .SPEED_Y(SY),
    .D_WIDTH(DW), .D_HEIGHT(DH), .SERVE_FRAMES(SF)
  ) dut (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .bus      (bus)
  );

  always #5 in_clock = ~in_clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the game: state 0=serve 1=play 2=scored; dx/dy 1 = right/down.
  int m_state, m_x, m_y, m_dx, m_dy, m_cnt, m_pl, m_pr;

  task automatic model_reset();
    m_state = 0; m_x = IX; m_y = IY; m_dx = 1; m_dy = 1; m_cnt = 0; m_pl = 0; m_pr = 0;
  endtask

  task automatic model_step();
    int ny, ndy, lx2, lt, lb, rx1, rt, rb, was_pl;
    bit stb, ovl, ovr;
    stb = bus.in_ani_stb && bus.in_animate;
    lx2 = int'(bus.in_lbar_x2); lt = int'(bus.in_lbar_y1); lb = int'(bus.in_lbar_y2);
    rx1 = int'(bus.in_rbar_x1); rt = int'(bus.in_rbar_y1); rb = int'(bus.in_rbar_y2);
    was_pl = m_pl; m_pl = 0; m_pr = 0;
    if (m_state == 2) begin
      m_state = 0; m_x = IX; m_y = IY; m_dy = 1; m_cnt = 0; m_dx = was_pl;
    end else if (m_state == 0) begin
      if (stb) begin
        if (m_cnt == SF - 1) begin m_cnt = 0; m_state = 1; end
        else m_cnt++;
      end
    end else if (stb) begin
      if (m_dy == 1 && m_y + SIZE + SY >= DH) begin ny = DH - 1 - SIZE; ndy = 0; end
      else if (m_dy == 0 && m_y <= SIZE + SY) begin ny = SIZE; ndy = 1; end
      else begin ny = (m_dy == 1) ? m_y + SY : m_y - SY; ndy = m_dy; end
      ovl = (m_y + SIZE >= lt) && (m_y - SIZE <= lb);
      ovr = (m_y + SIZE >= rt) && (m_y - SIZE <= rb);
      m_dy = ndy;
      if (m_dx == 0 && m_x - SIZE >= lx2 && m_x - SIZE - SX <= lx2 && ovl) begin
        m_x = (lx2 + SIZE + 1) & 4095; m_dx = 1; m_y = ny;
      end else if (m_dx == 1 && m_x + SIZE <= rx1 && m_x + SIZE + SX >= rx1 && ovr) begin
        m_x = (rx1 - SIZE - 1) & 4095; m_dx = 0; m_y = ny;
      end else if (m_dx == 0 && m_x <= SIZE + SX) begin
        m_state = 2; m_pr = 1;
      end else if (m_dx == 1 && m_x + SIZE + SX >= DW) begin
        m_state = 2; m_pl = 1;
      end else begin
        m_x = (m_dx == 1) ? m_x + SX : m_x - SX; m_y = ny;
      end
    end
  endtask

  function automatic logic [51:0] exp_vec();
    return {12'(m_x - SIZE), 12'(m_x + SIZE), 12'(m_y - SIZE), 12'(m_y + SIZE),
            1'(m_pl), 1'(m_pr), 2'(m_state)};
  endfunction

  function automatic logic [51:0] dut_vec();
    return {bus.out_x1, bus.out_x2, bus.out_y1, bus.out_y2,
            bus.out_point_l, bus.out_point_r, bus.out_state};
  endfunction

  task automatic tick();
    @(posedge in_clock);
    if (in_reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic strobe();
    bus.in_ani_stb = 1'b1;
    tick();
    bus.in_ani_stb = 1'b0;
  endtask

  task automatic apply_reset();
    in_reset = 1'b1;
    tick();
    in_reset = 1'b0;
  endtask

  task automatic set_paddles(int lx2, int lt, int lb, int rx1, int rt, int rb);
    bus.in_lbar_x2 = 12'(lx2); bus.in_lbar_y1 = 12'(lt); bus.in_lbar_y2 = 12'(lb);
    bus.in_rbar_x1 = 12'(rx1); bus.in_rbar_y1 = 12'(rt); bus.in_rbar_y2 = 12'(rb);
  endtask

  task automatic serve_out(string tag);
    for (int i = 0; i < SF; i++) begin
      strobe();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL %s serve strobe %0d: dut=%h model=%h", tag, i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset();
    #1 in_reset = 1'b1;
    #2;
    n_cmp++; if (bus.out_x1 !== 12'd312) begin n_bad++; $display("FAIL reset_x1: got %0d want 312", bus.out_x1); end
    n_cmp++; if (bus.out_x2 !== 12'd328) begin n_bad++; $display("FAIL reset_x2: got %0d want 328", bus.out_x2); end
    n_cmp++; if (bus.out_y1 !== 12'd232) begin n_bad++; $display("FAIL reset_y1: got %0d want 232", bus.out_y1); end
    n_cmp++; if (bus.out_y2 !== 12'd248) begin n_bad++; $display("FAIL reset_y2: got %0d want 248", bus.out_y2); end
    n_cmp++; if (bus.out_state !== SERVE) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus.out_state); end
    n_cmp++; if ({bus.out_point_l, bus.out_point_r} !== 2'b00) begin n_bad++; $display("FAIL reset_points: got %b want 00", {bus.out_point_l, bus.out_point_r}); end
    tick();
    in_reset = 1'b0;
  endtask

  task automatic test_serve();
    for (int i = 0; i < SF - 1; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      strobe();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL serve_step %0d: dut=%h model=%h", i, dut_vec(), exp_vec()); end
    end
    n_cmp++; if (bus.out_state !== SERVE) begin n_bad++; $display("FAIL serve_hold_state: got %0d want 0", bus.out_state); end
    n_cmp++; if ({bus.out_x1, bus.out_x2, bus.out_y1, bus.out_y2} !== {12'd312, 12'd328, 12'd232, 12'd248}) begin
      n_bad++; $display("FAIL serve_hold_pos: got %0d/%0d/%0d/%0d want 312/328/232/248", bus.out_x1, bus.out_x2, bus.out_y1, bus.out_y2);
    end
    strobe();
    n_cmp++; if (bus.out_state !== PLAY || bus.out_x1 !== 12'd312) begin n_bad++; $display("FAIL serve_to_play: state %0d x1 %0d want 1/312", bus.out_state, bus.out_x1); end
    strobe();
    n_cmp++; if (bus.out_x1 !== 12'd314 || bus.out_y1 !== 12'd234) begin n_bad++; $display("FAIL first_move: x1 %0d y1 %0d want 314/234", bus.out_x1, bus.out_y1); end
  endtask

  task automatic test_right_hit();
    int g;
    set_paddles(0, 4095, 4095, 619, 0, 470);
    for (g = 0; g < 400 && m_x != 610; g++) begin
      strobe();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL rhit_track: dut=%h model=%h", dut_vec(), exp_vec()); end
    end
    if (g >= 400) begin n_bad++; $display("FAIL rhit_timeout: model x %0d never reached 610", m_x); end
    n_cmp++; if (bus.out_x1 !== 12'd602) begin n_bad++; $display("FAIL rhit_reach: x1 %0d want 602", bus.out_x1); end
    strobe();
    n_cmp++; if (bus.out_x1 !== 12'd602) begin n_bad++; $display("FAIL rhit_stay: x1 %0d want 602", bus.out_x1); end
    strobe();
    n_cmp++; if (bus.out_x1 !== 12'd600) begin n_bad++; $display("FAIL rhit_reverse: x1 %0d want 600", bus.out_x1); end
  endtask

  task automatic test_freeze();
    logic [51:0] held;
    held = exp_vec();
    bus.in_animate = 1'b0;
    for (int i = 0; i < 10; i++) begin
      strobe();
      tick();
      n_cmp++;
      if (dut_vec() !== held) begin n_bad++; $display("FAIL freeze %0d: dut=%h held=%h", i, dut_vec(), held); end
    end
    bus.in_animate = 1'b1;
    #2 in_reset = 1'b1;
    #1;
    n_cmp++; if ({bus.out_x1, bus.out_x2, bus.out_y1, bus.out_y2} !== {12'd312, 12'd328, 12'd232, 12'd248}) begin
      n_bad++; $display("FAIL async_reset_pos: got %0d/%0d/%0d/%0d want 312/328/232/248", bus.out_x1, bus.out_x2, bus.out_y1, bus.out_y2);
    end
    n_cmp++; if (bus.out_state !== SERVE || {bus.out_point_l, bus.out_point_r} !== 2'b00) begin
      n_bad++; $display("FAIL async_reset_ctl: state %0d points %b want 0/00", bus.out_state, {bus.out_point_l, bus.out_point_r});
    end
    tick();
    in_reset = 1'b0;
  endtask

  task automatic test_right_miss();
    int g;
    apply_reset();
    set_paddles(0, 4095, 4095, 619, 4095, 4095);
    serve_out("rmiss");
    for (g = 0; g < 400 && m_x != 630; g++) begin
      strobe();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL rmiss_track: dut=%h model=%h", dut_vec(), exp_vec()); end
    end
    if (g >= 400) begin n_bad++; $display("FAIL rmiss_timeout: model x %0d never reached 630", m_x); end
    bus.in_ani_stb = 1'b1;
    tick();
    n_cmp++; if (bus.out_state !== SCORED || {bus.out_point_l, bus.out_point_r} !== 2'b10 || bus.out_x1 !== 12'd622) begin
      n_bad++; $display("FAIL rmiss_score: state %0d points %b x1 %0d want 2/10/622", bus.out_state, {bus.out_point_l, bus.out_point_r}, bus.out_x1);
    end
    tick();
    bus.in_ani_stb = 1'b0;
    n_cmp++; if (bus.out_state !== SERVE || bus.out_point_l !== 1'b0 || bus.out_x1 !== 12'd312 || bus.out_y1 !== 12'd232) begin
      n_bad++; $display("FAIL rmiss_reserve: state %0d pl %b x1 %0d y1 %0d want 0/0/312/232", bus.out_state, bus.out_point_l, bus.out_x1, bus.out_y1);
    end
    repeat (SF - 1) strobe();
    n_cmp++; if (bus.out_state !== SERVE) begin n_bad++; $display("FAIL scored_stb_ignored: state %0d want 0", bus.out_state); end
    strobe();
    strobe();
    n_cmp++; if (bus.out_x1 !== 12'd314) begin n_bad++; $display("FAIL rmiss_serve_dir: x1 %0d want 314", bus.out_x1); end
  endtask

  task automatic test_bottom_bounce();
    int g;
    apply_reset();
    set_paddles(0, 4095, 4095, 619, 4095, 4095);
    serve_out("bottom");
    for (g = 0; g < 300 && !(m_y == 460 && m_dy == 1); g++) begin
      strobe();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL bottom_track: dut=%h model=%h", dut_vec(), exp_vec()); end
    end
    if (g >= 300) begin n_bad++; $display("FAIL bottom_timeout: model y %0d", m_y); end
    strobe();
    n_cmp++; if (bus.out_y1 !== 12'd453) begin n_bad++; $display("FAIL bottom_bounce: y1 %0d want 453", bus.out_y1); end
    strobe();
    n_cmp++; if (bus.out_y1 !== 12'd451) begin n_bad++; $display("FAIL bottom_up: y1 %0d want 451", bus.out_y1); end
  endtask

  task automatic test_corner_miss();
    apply_reset();
    set_paddles(0, 4095, 4095, 510, 0, 470);
    serve_out("corner");
    for (int i = 0; i < 337; i++) begin
      strobe();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL corner_track %0d: dut=%h model=%h", i, dut_vec(), exp_vec()); end
    end
    n_cmp++; if (bus.out_x1 !== 12'd1 || bus.out_y1 !== 12'd1) begin n_bad++; $display("FAIL corner_setup: x1 %0d y1 %0d want 1/1", bus.out_x1, bus.out_y1); end
    strobe();
    n_cmp++; if (bus.out_state !== SCORED || {bus.out_point_l, bus.out_point_r} !== 2'b01 || bus.out_x1 !== 12'd1) begin
      n_bad++; $display("FAIL corner_score: state %0d points %b x1 %0d want 2/01/1", bus.out_state, {bus.out_point_l, bus.out_point_r}, bus.out_x1);
    end
    tick();
    n_cmp++; if (bus.out_state !== SERVE || bus.out_point_r !== 1'b0) begin n_bad++; $display("FAIL corner_reserve: state %0d pr %b want 0/0", bus.out_state, bus.out_point_r); end
    serve_out("corner2");
    strobe();
    n_cmp++; if (bus.out_x1 !== 12'd310) begin n_bad++; $display("FAIL corner_serve_dir: x1 %0d want 310", bus.out_x1); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        int lt, rt;
        lt = $urandom_range(0, 400);
        rt = $urandom_range(0, 400);
        set_paddles($urandom_range(0, 40), lt, lt + $urandom_range(0, 300),
                     $urandom_range(600, 639), rt, rt + $urandom_range(0, 300));
        if ($urandom_range(0, 5) == 0) begin bus.in_lbar_y1 = 12'd4095; bus.in_lbar_y2 = 12'd4095; end
        if ($urandom_range(0, 5) == 0) begin bus.in_rbar_y1 = 12'd4095; bus.in_rbar_y2 = 12'd4095; end
      end
      bus.in_ani_stb = ($urandom_range(0, 1) == 1);
      bus.in_animate = ($urandom_range(0, 7) != 0);
      in_reset = ($urandom_range(0, 999) == 0);
      tick();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin n_bad++; $display("FAIL random cycle %0d: dut=%h model=%h", c, dut_vec(), exp_vec()); end
    end
    in_reset = 1'b0;
    bus.in_ani_stb = 1'b0;
  endtask

  initial begin
    bus.in_ani_stb = 1'b0;
    bus.in_animate = 1'b1;
    set_paddles(0, 4095, 4095, 4095, 4095, 4095);
    model_reset();
    test_reset();
    test_serve();
    test_right_hit();
    test_freeze();
    test_right_miss();
    test_bottom_bounce();
    test_corner_miss();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
